// File: rtl/gray_pkg.sv
// Shared constants, tracker state encoding and a Gray-to-binary reference
// function for the Gray-count decoder.
package gray_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_ERRW   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Plain serial prefix-XOR, kept only as a reference model for the bench.
    function automatic logic [DEF_WIDTH-1:0] gray2bin(input logic [DEF_WIDTH-1:0] gv);
        logic [DEF_WIDTH-1:0] bv;
        bv[DEF_WIDTH-1] = gv[DEF_WIDTH-1];
        for (int i = DEF_WIDTH - 2; i >= 0; i--) begin
            bv[i] = bv[i+1] ^ gv[i];
        end
        return bv;
    endfunction

endpackage

// File: rtl/gray2bin_stage.sv
// One registered stage of the Gray-to-binary pipeline: resolves bits HI..LO
// using the already-decoded bit HI+1 (or nothing, for the MSB chunk).
module gray2bin_stage #(
    parameter int WIDTH = 32,
    parameter int LO    = 24,
    parameter int HI    = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_word
);

    logic             carry_in;
    logic [WIDTH-1:0] word_d;

    if (HI == WIDTH - 1) begin : g_top_chunk
        assign carry_in = 1'b0;
    end else begin : g_inner_chunk
        assign carry_in = in_word[HI+1];
    end

    always_comb begin
        logic acc;
        word_d = in_word;
        acc    = carry_in;
        for (int i = HI; i >= LO; i--) begin
            acc       = acc ^ in_word[i];
            word_d[i] = acc;
        end
    end

    // The word only loads on valid, so the final stage holds its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_word  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_word <= word_d;
            end
        end
    end

endmodule

// File: rtl/gray_count_decoder.sv
// Pipelined Gray-to-binary decoder with a step checker that flags any
// decoded step other than +0 or +1 (modulo 2^WIDTH).
module gray_count_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int ERRW   = DEF_ERRW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             g_valid,
    input  logic [WIDTH-1:0] g,
    input  logic             resync,
    input  logic             clr_err,
    output logic             b_valid,
    output logic [WIDTH-1:0] b,
    output logic             chk_valid,
    output logic             chk_ok,
    output logic             chk_hold,
    output logic             err_flag,
    output logic [ERRW-1:0]  err_cnt,
    output logic             tracking
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

    logic [STAGES:0][WIDTH-1:0] pipe_word;
    logic [STAGES:0]            pipe_valid;

    assign pipe_word[0]  = g;
    assign pipe_valid[0] = g_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray2bin_stage #(
            .WIDTH (WIDTH),
            .LO    (WIDTH - (k + 1) * CHUNK),
            .HI    (WIDTH - 1 - k * CHUNK)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (pipe_valid[k]),
            .in_word   (pipe_word[k]),
            .out_valid (pipe_valid[k+1]),
            .out_word  (pipe_word[k+1])
        );
    end

    assign b_valid = pipe_valid[STAGES];
    assign b       = pipe_word[STAGES];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] delta;
    logic             chk_valid_d, chk_ok_d, chk_hold_d, step_err;

    assign delta    = b - prev_q;
    assign tracking = (state_q == TRACK);

    // resync wins over a coincident b_valid: that sample is neither checked
    // nor used as the reference.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        chk_valid_d = 1'b0;
        chk_ok_d    = 1'b0;
        chk_hold_d  = 1'b0;
        step_err    = 1'b0;
        if (resync) begin
            state_d = IDLE;
        end else if (b_valid) begin
            prev_d = b;
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                end
                TRACK: begin
                    chk_valid_d = 1'b1;
                    if (delta == WIDTH'(1)) begin
                        chk_ok_d = 1'b1;
                    end else if (delta == '0) begin
                        chk_hold_d = 1'b1;
                    end else begin
                        step_err = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            chk_valid <= 1'b0;
            chk_ok    <= 1'b0;
            chk_hold  <= 1'b0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            chk_valid <= chk_valid_d;
            chk_ok    <= chk_ok_d;
            chk_hold  <= chk_hold_d;
            // A clear takes effect before an error detected in the same cycle.
            if (clr_err) begin
                err_flag <= step_err;
                err_cnt  <= step_err ? ERRW'(1) : '0;
            end else if (step_err) begin
                err_flag <= 1'b1;
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + ERRW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_count_decoder.sv
// Directed bench for gray_count_decoder: expected words and step results are
// queued at issue time and popped by an independent output monitor.
module tb_gray_count_decoder;
    import gray_pkg::*;

    localparam int W      = 32;
    localparam int STG    = 4;
    localparam int EW     = 16;
    localparam int CK_NONE = -1;
    localparam int CK_BAD  = 0;
    localparam int CK_HOLD = 1;
    localparam int CK_OK   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          g_valid = 1'b0;
    logic [W-1:0]  g = '0;
    logic          resync = 1'b0;
    logic          clr_err = 1'b0;
    logic          b_valid;
    logic [W-1:0]  b;
    logic          chk_valid, chk_ok, chk_hold, err_flag, tracking;
    logic [EW-1:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    int           exp_t_q[$];
    logic [1:0]   exp_c_q[$];

    gray_count_decoder #(.WIDTH(W), .STAGES(STG), .ERRW(EW)) dut (
        .clk       (clk),
        .reset     (reset),
        .g_valid   (g_valid),
        .g         (g),
        .resync    (resync),
        .clr_err   (clr_err),
        .b_valid   (b_valid),
        .b         (b),
        .chk_valid (chk_valid),
        .chk_ok    (chk_ok),
        .chk_hold  (chk_hold),
        .err_flag  (err_flag),
        .err_cnt   (err_cnt),
        .tracking  (tracking)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic flag_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=unexpected required=none", name);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (b_valid) begin
                if (exp_q.size() == 0) begin
                    flag_fail("b_valid_extra");
                end else begin
                    check("b_value", b, exp_q.pop_front());
                    check("b_latency", W'(cyc - exp_t_q.pop_front()), W'(STG));
                end
            end
            if (chk_valid) begin
                if (exp_c_q.size() == 0) begin
                    flag_fail("chk_valid_extra");
                end else begin
                    check("chk_ok_hold", W'({chk_ok, chk_hold}), W'(exp_c_q.pop_front()));
                end
            end else if (chk_ok || chk_hold) begin
                flag_fail("chk_pulse_without_valid");
            end
        end
    end

    // driver tasks
    task automatic send(input logic [W-1:0] gv, input logic [W-1:0] eb, input int ck);
        g_valid = 1'b1;
        g       = gv;
        exp_q.push_back(eb);
        exp_t_q.push_back(cyc);
        if (ck != CK_NONE) exp_c_q.push_back(ck[1:0]);
        @(negedge clk);
        g_valid = 1'b0;
        g       = '0;
    endtask

    task automatic pulse_resync();
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_c_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) flag_fail({name, "_drain_timeout"});
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_b_valid", W'(b_valid), 0);
        check("rst_b", b, 0);
        check("rst_chk", W'({chk_valid, chk_ok, chk_hold}), 0);
        check("rst_err", W'({err_flag, err_cnt}), 0);
        check("rst_tracking", W'(tracking), 0);
        reset = 1'b0;
        @(negedge clk);

        // first sample becomes the reference, no step check
        send(32'h0000_0007, 32'h0000_0005, CK_NONE);
        check("idle_tracking_before", W'(tracking), 0);
        drain("first");
        check("tracking_after_first", W'(tracking), 1);

        // +1 then +0
        send(32'h0000_0005, 32'h0000_0006, CK_OK);
        send(32'h0000_0005, 32'h0000_0006, CK_HOLD);
        drain("ok_hold");
        check("err_flag_after_ok_hold", W'(err_flag), 0);

        // wrap-around 0xFFFFFFFF -> 0
        pulse_resync();
        check("tracking_after_resync", W'(tracking), 0);
        send(32'h8000_0000, 32'hFFFF_FFFF, CK_NONE);
        send(32'h0000_0000, 32'h0000_0000, CK_OK);
        drain("wrap");
        check("err_cnt_after_wrap", W'(err_cnt), 0);

        // illegal jump 5 -> 9, then 10 is legal again
        pulse_resync();
        send(32'h0000_0007, 32'h0000_0005, CK_NONE);
        send(32'h0000_000D, 32'h0000_0009, CK_BAD);
        send(32'h0000_000F, 32'h0000_000A, CK_OK);
        drain("jump");
        check("err_flag_after_jump", W'(err_flag), 1);
        check("err_cnt_after_jump", W'(err_cnt), 1);

        // clear coincident with an illegal step (10 -> 20)
        send(32'h0000_001E, 32'h0000_0014, CK_BAD);
        repeat (3) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        drain("clr_same_cycle");
        check("err_cnt_clr_same", W'(err_cnt), 1);
        check("err_flag_clr_same", W'(err_flag), 1);

        // saturation: alternate binary 0 / 5, every step illegal
        for (int i = 0; i < 65540; i++) begin
            if (i[0]) send(32'h0000_0007, 32'h0000_0005, CK_BAD);
            else      send(32'h0000_0000, 32'h0000_0000, CK_BAD);
        end
        drain("saturate");
        check("err_cnt_saturated", W'(err_cnt), 32'h0000_FFFF);
        check("err_flag_saturated", W'(err_flag), 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        check("err_cnt_cleared", W'({err_flag, err_cnt}), 0);

        // reset with three samples in flight
        send(32'h0000_0001, 32'h0000_0001, CK_OK);
        send(32'h0000_0003, 32'h0000_0002, CK_OK);
        send(32'h0000_0002, 32'h0000_0003, CK_OK);
        reset = 1'b1;
        exp_q.delete();
        exp_t_q.delete();
        exp_c_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_b", b, 0);
        check("midrst_valids", W'({b_valid, chk_valid, chk_ok, chk_hold}), 0);
        check("midrst_err", W'({err_flag, err_cnt}), 0);
        check("midrst_tracking", W'(tracking), 0);

        // resync: new reference after the pulse
        send(32'h0000_002B, 32'h0000_0032, CK_NONE);
        drain("ref50");
        check("tracking_ref50", W'(tracking), 1);
        pulse_resync();
        send(32'h0000_0056, 32'h0000_0064, CK_NONE);
        send(32'h0000_0057, 32'h0000_0065, CK_OK);
        drain("resync");
        check("err_flag_resync", W'(err_flag), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
